// File: rtl/adc_delay_calibrator.sv
// rtl/adc_delay_calibrator.sv - ADC IDELAY tap sweep calibrator
// Sweeps every tap, scores it by the pattern validator and loads the centre of the longest passing window.
module adc_delay_calibrator #(
  parameter int TAP_WIDTH     = 5,
  parameter int SETTLE_CYCLES = 16,
  parameter int DWELL_CYCLES  = 140000
) (
  input  logic                 aclk,
  input  logic                 resetn,
  input  logic                 start,
  input  logic                 pattern_valid,
  output logic                 checker_resetn,
  output logic [TAP_WIDTH-1:0] tap_value,
  output logic                 tap_load,
  output logic                 busy,
  output logic                 done,
  output logic                 locked,
  output logic                 error,
  output logic [TAP_WIDTH-1:0] window_start,
  output logic [TAP_WIDTH:0]   window_len
);

  localparam int LW = TAP_WIDTH + 1;
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int DW = $clog2(DWELL_CYCLES + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_DWELL  = 3'd3;
  localparam logic [2:0] S_EVAL   = 3'd4;
  localparam logic [2:0] S_FINAL  = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  localparam logic [TAP_WIDTH-1:0] TAP_MAX       = '1;
  localparam logic [SW-1:0]        SETTLE_RELOAD = SW'(SETTLE_CYCLES - 1);
  localparam logic [DW-1:0]        DWELL_RELOAD  = DW'(DWELL_CYCLES - 1);

  logic [2:0]           r_state;
  logic [TAP_WIDTH-1:0] r_tap;
  logic [SW-1:0]        r_settle_cnt;
  logic [DW-1:0]        r_dwell_cnt;
  logic                 r_pass;
  logic [TAP_WIDTH-1:0] r_cur_start;
  logic [LW-1:0]        r_cur_len;
  logic [TAP_WIDTH-1:0] r_best_start;
  logic [LW-1:0]        r_best_len;

  logic [LW-1:0]        w_cur_len_nxt;
  logic [TAP_WIDTH-1:0] w_cur_start_nxt;
  logic                 w_best_upd;
  logic [LW-1:0]        w_best_len_nxt;
  logic [TAP_WIDTH-1:0] w_best_start_nxt;
  logic [TAP_WIDTH-1:0] w_half;
  logic [TAP_WIDTH-1:0] w_centre_tap;

  // Run statistics as they will be after the current EVAL, so the last tap is scored before FINAL.
  assign w_cur_len_nxt    = r_pass ? (r_cur_len + LW'(1)) : '0;
  assign w_cur_start_nxt  = (r_pass && (r_cur_len == '0)) ? r_tap : r_cur_start;
  assign w_best_upd       = (w_cur_len_nxt > r_best_len);
  assign w_best_len_nxt   = w_best_upd ? w_cur_len_nxt : r_best_len;
  assign w_best_start_nxt = w_best_upd ? w_cur_start_nxt : r_best_start;
  assign w_half           = TAP_WIDTH'((w_best_len_nxt - LW'(1)) >> 1);
  assign w_centre_tap     = (w_best_len_nxt == '0) ? '0 : (w_best_start_nxt + w_half);

  always_ff @(posedge aclk) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_tap        <= '0;
      r_settle_cnt <= '0;
      r_dwell_cnt  <= '0;
      r_pass       <= 1'b0;
      r_cur_start  <= '0;
      r_cur_len    <= '0;
      r_best_start <= '0;
      r_best_len   <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state      <= S_LOAD;
            r_tap        <= '0;
            r_cur_start  <= '0;
            r_cur_len    <= '0;
            r_best_start <= '0;
            r_best_len   <= '0;
          end
        end
        S_LOAD: begin
          r_settle_cnt <= SETTLE_RELOAD;
          r_state      <= S_SETTLE;
        end
        S_SETTLE: begin
          if (r_settle_cnt == '0) begin
            r_dwell_cnt <= DWELL_RELOAD;
            r_state     <= S_DWELL;
          end else begin
            r_settle_cnt <= r_settle_cnt - SW'(1);
          end
        end
        S_DWELL: begin
          if (pattern_valid) begin
            r_pass  <= 1'b1;
            r_state <= S_EVAL;
          end else if (r_dwell_cnt == '0) begin
            r_pass  <= 1'b0;
            r_state <= S_EVAL;
          end else begin
            r_dwell_cnt <= r_dwell_cnt - DW'(1);
          end
        end
        S_EVAL: begin
          r_cur_len    <= w_cur_len_nxt;
          r_cur_start  <= w_cur_start_nxt;
          r_best_len   <= w_best_len_nxt;
          r_best_start <= w_best_start_nxt;
          if (r_tap == TAP_MAX) begin
            r_tap   <= w_centre_tap;
            r_state <= S_FINAL;
          end else begin
            r_tap   <= r_tap + TAP_WIDTH'(1);
            r_state <= S_LOAD;
          end
        end
        S_FINAL: r_state <= S_DONE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign tap_value      = r_tap;
  assign tap_load       = (r_state == S_LOAD) || (r_state == S_FINAL);
  assign checker_resetn = !((r_state == S_LOAD) || (r_state == S_SETTLE));
  assign busy           = (r_state != S_IDLE) && (r_state != S_DONE);
  assign done           = (r_state == S_DONE);
  assign locked         = done && (r_best_len != '0);
  assign error          = done && (r_best_len == '0);
  assign window_start   = r_best_start;
  assign window_len     = r_best_len;

endmodule
